// File: rtl/bitstream_collector.sv
// bitstream_collector: buffers encoder byte groups in a circular FIFO and serialises them one byte per cycle
module bitstream_collector #(
    parameter int BC_BITSTREAM_WIDTH = 8,
    parameter int BC_FIFO_ADDR_WIDTH = 4,
    parameter int BC_COUNT_WIDTH     = 32
) (
    input  logic                          bc_clk,
    input  logic                          bc_reset,
    input  logic                          bc_start,
    input  logic [BC_BITSTREAM_WIDTH-1:0] in_bit_1,
    input  logic [BC_BITSTREAM_WIDTH-1:0] in_bit_2,
    input  logic [BC_BITSTREAM_WIDTH-1:0] in_bit_3,
    input  logic [BC_BITSTREAM_WIDTH-1:0] in_last_bit,
    input  logic [2:0]                    in_flag_bitstream,
    input  logic                          in_flag_last,
    input  logic                          in_error,
    output logic [BC_BITSTREAM_WIDTH-1:0] out_byte,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [BC_COUNT_WIDTH-1:0]     out_byte_count,
    output logic                          out_done,
    output logic                          out_overflow,
    output logic                          out_err_protocol,
    output logic                          out_err_encoder
);
    localparam int AW = BC_FIFO_ADDR_WIDTH;
    localparam int CNTW = AW + 1;
    localparam logic [AW:0] DEPTH = CNTW'(1 << AW);

    typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

    state_t                        state_q, state_d, cur_state;
    logic [AW-1:0]                 wr_q, wr_d, rd_q, rd_d, cur_wr, cur_rd;
    logic [AW:0]                   cnt_q, cnt_d, cur_cnt, free, n_ext, wr_n;
    logic [BC_COUNT_WIDTH-1:0]     bcnt_q, bcnt_d, cur_bcnt;
    logic                          ovf_q, ovf_d, prot_q, prot_d, enc_q, enc_d;
    logic [BC_BITSTREAM_WIDTH:0]   mem [1 << AW];
    logic [BC_BITSTREAM_WIDTH:0]   grp [4];
    logic [3:0]                    n;
    logic                          collect, illegal, wr_en, pop;

    assign out_valid        = (cnt_q != '0) && (state_q != DONE);
    assign out_byte         = out_valid ? mem[rd_q][BC_BITSTREAM_WIDTH-1:0] : '0;
    assign out_last         = out_valid & mem[rd_q][BC_BITSTREAM_WIDTH];
    assign out_done         = state_q == DONE;
    assign out_byte_count   = bcnt_q;
    assign out_overflow     = ovf_q;
    assign out_err_protocol = prot_q;
    assign out_err_encoder  = enc_q;

    // Arrange the incoming group in stream order; the tagged final byte follows the counted bytes
    always_comb begin
        for (int k = 0; k < 4; k++)
            grp[k] = (3'(k) < in_flag_bitstream)
                   ? {1'b0, (k == 0) ? in_bit_1 : (k == 1) ? in_bit_2 : in_bit_3}
                   : {1'b1, in_last_bit};
    end

    // Next-state logic: a start pulse rebases everything to an empty stream before the group is judged
    always_comb begin
        cur_state = bc_start ? COLLECT : state_q;
        cur_wr    = bc_start ? '0 : wr_q;
        cur_rd    = bc_start ? '0 : rd_q;
        cur_cnt   = bc_start ? '0 : cnt_q;
        cur_bcnt  = bc_start ? '0 : bcnt_q;
        n         = {1'b0, in_flag_bitstream} + {3'b0, in_flag_last};
        n_ext     = CNTW'(n);
        free      = DEPTH - cur_cnt;
        collect   = cur_state == COLLECT;
        illegal   = in_flag_bitstream > 3'd3;
        wr_en     = collect && !illegal && (n != 4'd0) && (n_ext <= free);
        wr_n      = wr_en ? n_ext : '0;
        pop       = out_valid && out_ready && !bc_start;
        wr_d      = cur_wr + AW'(n_ext & {CNTW{wr_en}});
        rd_d      = cur_rd + AW'(pop);
        cnt_d     = cur_cnt + wr_n - CNTW'(pop);
        bcnt_d    = cur_bcnt + BC_COUNT_WIDTH'(pop);
        ovf_d     = (ovf_q && !bc_start) || (collect && !illegal && (n_ext > free));
        prot_d    = (prot_q && !bc_start) || (collect ? illegal : (n != 4'd0));
        enc_d     = (enc_q && !bc_start) || in_error;
        state_d   = cur_state;
        if (wr_en && in_flag_last)
            state_d = DRAIN;
        if (state_q == DRAIN && pop && mem[rd_q][BC_BITSTREAM_WIDTH])
            state_d = DONE;
    end

    // State, pointer, counter and sticky flag registers
    always_ff @(posedge bc_clk or posedge bc_reset) begin
        if (bc_reset) begin
            state_q <= COLLECT;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            ovf_q   <= 1'b0;
            prot_q  <= 1'b0;
            enc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            ovf_q   <= ovf_d;
            prot_q  <= prot_d;
            enc_q   <= enc_d;
        end
    end

    // FIFO storage: an accepted group lands contiguously from the write pointer, wrapping modulo depth
    always_ff @(posedge bc_clk) begin
        for (int k = 0; k < 4; k++)
            if (wr_en && (4'(k) < n))
                mem[cur_wr + AW'(k)] <= grp[k];
    end
endmodule
